// File: rtl/mem_bridge_pkg.sv
// rtl/mem_bridge_pkg.sv - shared widths, funct3 size codes and bridge state encoding
package mem_bridge_pkg;

    localparam int XLEN = 32;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_RESP = 2'd2
    } state_e;

endpackage

// File: rtl/mem_bridge_if.sv
// rtl/mem_bridge_if.sv - CPU instruction/data channels and external memory port of the bridge
interface mem_bridge_if;
    import mem_bridge_pkg::*;

    logic            i_inst_req;
    logic [XLEN-1:0] i_inst_addr;
    logic            o_inst_ack;
    logic [XLEN-1:0] o_inst_data;

    logic            i_data_req;
    logic [XLEN-1:0] i_data_addr;
    logic [XLEN-1:0] i_data_wdata;
    logic [2:0]      i_funct3;
    logic            i_read_write;
    logic            o_data_ack;
    logic [XLEN-1:0] o_data_rdata;

    logic            o_mem_req;
    logic            o_mem_we;
    logic [XLEN-1:0] o_mem_addr;
    logic [XLEN-1:0] o_mem_wdata;
    logic [3:0]      o_mem_wstrb;
    logic            i_mem_ack;
    logic [XLEN-1:0] i_mem_rdata;

    logic            o_bus_err;

    modport slave (
        input  i_inst_req, i_inst_addr,
        output o_inst_ack, o_inst_data,
        input  i_data_req, i_data_addr, i_data_wdata, i_funct3, i_read_write,
        output o_data_ack, o_data_rdata,
        output o_mem_req, o_mem_we, o_mem_addr, o_mem_wdata, o_mem_wstrb,
        input  i_mem_ack, i_mem_rdata,
        output o_bus_err
    );

    modport master (
        output i_inst_req, i_inst_addr,
        input  o_inst_ack, o_inst_data,
        output i_data_req, i_data_addr, i_data_wdata, i_funct3, i_read_write,
        input  o_data_ack, o_data_rdata,
        input  o_mem_req, o_mem_we, o_mem_addr, o_mem_wdata, o_mem_wstrb,
        output i_mem_ack, i_mem_rdata,
        input  o_bus_err
    );

endinterface

// File: rtl/mem_lane_align.sv
// rtl/mem_lane_align.sv - combinational store lane/strobe generation, load extract/extend, alignment check
module mem_lane_align
    import mem_bridge_pkg::*;
(
    input  logic [1:0]      addr_lo_i,
    input  logic [2:0]      funct3_i,
    input  logic            store_i,
    input  logic [XLEN-1:0] wdata_i,
    input  logic [XLEN-1:0] rdata_i,
    output logic [3:0]      wstrb_o,
    output logic [XLEN-1:0] wdata_o,
    output logic [XLEN-1:0] rdata_o,
    output logic            illegal_o
);

    logic [7:0]  sel_byte;
    logic [15:0] sel_half;

    always_comb begin
        sel_byte = rdata_i[{addr_lo_i, 3'b000} +: 8];
        sel_half = rdata_i[{addr_lo_i[1], 4'b0000} +: 16];

        // funct3[1:0] is the access size for both loads and stores
        case (funct3_i[1:0])
            2'b00: begin
                wstrb_o = 4'b0001 << addr_lo_i;
                wdata_o = {(XLEN/8){wdata_i[7:0]}};
            end
            2'b01: begin
                wstrb_o = 4'b0011 << {addr_lo_i[1], 1'b0};
                wdata_o = {(XLEN/16){wdata_i[15:0]}};
            end
            default: begin
                wstrb_o = 4'b1111;
                wdata_o = wdata_i;
            end
        endcase

        case (funct3_i)
            F3_B:    rdata_o = {{(XLEN-8){sel_byte[7]}}, sel_byte};
            F3_H:    rdata_o = {{(XLEN-16){sel_half[15]}}, sel_half};
            F3_BU:   rdata_o = {{(XLEN-8){1'b0}}, sel_byte};
            F3_HU:   rdata_o = {{(XLEN-16){1'b0}}, sel_half};
            default: rdata_o = rdata_i;
        endcase

        case (funct3_i)
            F3_B, F3_BU: illegal_o = 1'b0;
            F3_H, F3_HU: illegal_o = addr_lo_i[0];
            F3_W:        illegal_o = (addr_lo_i != 2'b00);
            default:     illegal_o = 1'b1;
        endcase
        if (store_i && funct3_i[2]) begin
            illegal_o = 1'b1;
        end
    end

endmodule

// File: rtl/mem_bridge.sv
// rtl/mem_bridge.sv - arbitrates CPU instruction/data requests onto one word-wide memory port
module mem_bridge
    import mem_bridge_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic        i_clk,
    input  logic        i_rst_n,
    mem_bridge_if.slave bus
);

    localparam logic [7:0] TIMEOUT_LIMIT = 8'(TIMEOUT_CYCLES);

    state_e          state_q, state_d;
    logic [7:0]      cnt_q, cnt_d, cnt_inc;
    logic [XLEN-1:0] addr_q, addr_d;
    logic [XLEN-1:0] wdata_q, wdata_d;
    logic [XLEN-1:0] rdata_q, rdata_d;
    logic [2:0]      f3_q, f3_d;
    logic [3:0]      strb_q, strb_d;
    logic            we_q, we_d;
    logic            owner_data_q, owner_data_d;
    logic            err_q, err_d;

    logic [1:0]      al_addr;
    logic [2:0]      al_f3;
    logic            al_store;
    logic [3:0]      al_strb;
    logic [XLEN-1:0] al_wdata;
    logic [XLEN-1:0] al_rdata;
    logic            al_illegal;

    // In IDLE the aligner sees the arbitration winner; afterwards the latched access
    always_comb begin
        al_addr  = addr_q[1:0];
        al_f3    = f3_q;
        al_store = we_q;
        if (state_q == ST_IDLE) begin
            if (bus.i_data_req) begin
                al_addr  = bus.i_data_addr[1:0];
                al_f3    = bus.i_funct3;
                al_store = bus.i_read_write;
            end else begin
                al_addr  = bus.i_inst_addr[1:0];
                al_f3    = F3_W;
                al_store = 1'b0;
            end
        end
    end

    mem_lane_align u_align (
        .addr_lo_i (al_addr),
        .funct3_i  (al_f3),
        .store_i   (al_store),
        .wdata_i   (bus.i_data_wdata),
        .rdata_i   (bus.i_mem_rdata),
        .wstrb_o   (al_strb),
        .wdata_o   (al_wdata),
        .rdata_o   (al_rdata),
        .illegal_o (al_illegal)
    );

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        addr_d       = addr_q;
        wdata_d      = wdata_q;
        rdata_d      = rdata_q;
        f3_d         = f3_q;
        strb_d       = strb_q;
        we_d         = we_q;
        owner_data_d = owner_data_q;
        err_d        = err_q;
        cnt_inc      = cnt_q + 8'd1;

        case (state_q)
            ST_IDLE: begin
                if (bus.i_data_req || bus.i_inst_req) begin
                    owner_data_d = bus.i_data_req;
                    addr_d       = bus.i_data_req ? bus.i_data_addr : bus.i_inst_addr;
                    f3_d         = al_f3;
                    we_d         = al_store;
                    wdata_d      = al_wdata;
                    strb_d       = al_store ? al_strb : 4'b0000;
                    rdata_d      = '0;
                    cnt_d        = 8'd0;
                    err_d        = al_illegal;
                    state_d      = al_illegal ? ST_RESP : ST_BUSY;
                end
            end
            ST_BUSY: begin
                // A late ack on the final counted cycle still completes normally
                if (bus.i_mem_ack) begin
                    rdata_d = we_q ? '0 : al_rdata;
                    state_d = ST_RESP;
                end else if (cnt_inc == TIMEOUT_LIMIT) begin
                    err_d   = 1'b1;
                    rdata_d = '0;
                    state_d = ST_RESP;
                end else begin
                    cnt_d = cnt_inc;
                end
            end
            ST_RESP: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q      <= ST_IDLE;
            cnt_q        <= 8'd0;
            addr_q       <= '0;
            wdata_q      <= '0;
            rdata_q      <= '0;
            f3_q         <= 3'b000;
            strb_q       <= 4'b0000;
            we_q         <= 1'b0;
            owner_data_q <= 1'b0;
            err_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            addr_q       <= addr_d;
            wdata_q      <= wdata_d;
            rdata_q      <= rdata_d;
            f3_q         <= f3_d;
            strb_q       <= strb_d;
            we_q         <= we_d;
            owner_data_q <= owner_data_d;
            err_q        <= err_d;
        end
    end

    logic resp, busy;
    assign resp = (state_q == ST_RESP);
    assign busy = (state_q == ST_BUSY);

    assign bus.o_inst_ack   = resp && !owner_data_q;
    assign bus.o_data_ack   = resp && owner_data_q;
    assign bus.o_inst_data  = (resp && !owner_data_q) ? rdata_q : '0;
    assign bus.o_data_rdata = (resp && owner_data_q) ? rdata_q : '0;
    assign bus.o_bus_err    = resp && err_q;

    assign bus.o_mem_req    = busy;
    assign bus.o_mem_we     = busy && we_q;
    assign bus.o_mem_addr   = {addr_q[XLEN-1:2], 2'b00};
    assign bus.o_mem_wdata  = wdata_q;
    assign bus.o_mem_wstrb  = busy ? strb_q : 4'b0000;

endmodule
